// File: rtl/soc_evt_pkg.sv
// Shared definitions for the SoC-to-cluster event channel.
// Contents:
//   bin2gray / gray2bin - pointer encoding helpers. They work on 32-bit values;
//                         callers cast to and from their own pointer width.
//   ptr_w               - pointer/token width for a given buffer depth.
//   evt_id_t            - event ID type at the default ID width.
package soc_evt_pkg;

  localparam int EVNT_WIDTH_DEF = 8;

  typedef logic [EVNT_WIDTH_DEF-1:0] evt_id_t;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Bits above the caller's width are zero, so the prefix XOR from the MSB
  // produces the correct result for any narrower pointer.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // One extra bit beyond the slot index separates the full state from the
  // empty state.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/soc_evt_rr_arb.sv
// Round-robin arbiter for the event sources.
// Ports:
//   req_i       - per-source request vector
//   rr_i        - index where the cyclic search for a valid request starts
//   en_i        - grant enable; when low, no grant is issued
//   grant_o     - one-hot grant, all zero when there is no grant
//   gnt_idx_o   - index of the granted source; only meaningful when gnt_valid_o is high
//   gnt_valid_o - a grant is issued this cycle
module soc_evt_rr_arb #(
  parameter int N_SRC = 4,
  localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic [N_SRC-1:0] req_i,
  input  logic [IDX_W-1:0] rr_i,
  input  logic             en_i,
  output logic [N_SRC-1:0] grant_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             gnt_valid_o
);

  logic             w_found;
  logic [IDX_W-1:0] w_idx;
  logic [IDX_W-1:0] w_cand;

  // The first requester at or after rr_i, searching cyclically, wins.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_cand  = '0;
    for (int k = 0; k < N_SRC; k++) begin
      w_cand = IDX_W'((int'(rr_i) + k) % N_SRC);
      if (!w_found && req_i[w_cand]) begin
        w_found = 1'b1;
        w_idx   = w_cand;
      end
    end
  end

  assign gnt_valid_o = en_i & w_found;
  assign gnt_idx_o   = w_idx;
  assign grant_o     = gnt_valid_o ? (N_SRC'(1) << w_idx) : '0;

endmodule

// File: rtl/soc_evt_dc_tx.sv
// Producer side of the SoC-to-cluster event channel.
// Several event sources are round-robin arbitrated into a multi-slot buffer.
// The buffer is exported together with a Gray-coded write token; the reader
// returns a Gray read pointer already synchronised into clk_i.
// Ports:
//   clk_i, rst_ni - clock, asynchronous active-low reset
//   enable_i      - grant enable (buffered data and pointer tracking persist when low)
//   src_valid_i   - per-source event request
//   src_id_i      - per-source event ID, held while its request is valid
//   src_ack_o     - one-cycle accept pulse to the granted source
//   evt_wt_o      - Gray write token
//   evt_rp_i      - Gray read pointer from the reader
//   evt_da_o      - slot array read by the reader at its pointer
//   fill_o        - occupied slots, 0..BUFFER_DEPTH
//   full_o        - no free slot
//   err_o         - sticky flag: the read pointer was ever out of range
module soc_evt_dc_tx
  import soc_evt_pkg::*;
#(
  parameter int N_SRC        = 4,
  parameter int EVNT_WIDTH   = 8,
  parameter int BUFFER_DEPTH = 8,
  localparam int PTR_W       = ptr_w(BUFFER_DEPTH),
  localparam int IDX_W       = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   enable_i,
  input  logic [N_SRC-1:0]                       src_valid_i,
  input  logic [N_SRC-1:0][EVNT_WIDTH-1:0]       src_id_i,
  output logic [N_SRC-1:0]                       src_ack_o,
  output logic [PTR_W-1:0]                       evt_wt_o,
  input  logic [PTR_W-1:0]                       evt_rp_i,
  output logic [BUFFER_DEPTH-1:0][EVNT_WIDTH-1:0] evt_da_o,
  output logic [PTR_W-1:0]                       fill_o,
  output logic                                   full_o,
  output logic                                   err_o
);

  logic [PTR_W-1:0]                        r_wptr;
  logic [PTR_W-1:0]                        r_wt;
  logic [BUFFER_DEPTH-1:0][EVNT_WIDTH-1:0] r_slot;
  logic [IDX_W-1:0]                        r_rr;
  logic                                    r_err;

  logic [PTR_W-1:0] w_rptr_bin;
  logic [PTR_W-1:0] w_diff;
  logic [PTR_W-1:0] w_wptr_nxt;
  logic             w_full;
  logic             w_oob;
  logic             w_gnt;
  logic [IDX_W-1:0] w_gidx;
  logic [IDX_W-1:0] w_rr_nxt;

  assign w_rptr_bin = PTR_W'(gray2bin(32'(evt_rp_i)));
  // Modulo-2^PTR_W subtraction gives occupancy across pointer wrap.
  assign w_diff     = r_wptr - w_rptr_bin;
  // A difference beyond the depth can only come from a corrupt read pointer;
  // treating it as full stops any slot from being overwritten.
  assign w_oob      = (w_diff > PTR_W'(BUFFER_DEPTH));
  assign w_full     = (w_diff >= PTR_W'(BUFFER_DEPTH));
  assign w_wptr_nxt = r_wptr + PTR_W'(1);

  soc_evt_rr_arb #(
    .N_SRC (N_SRC)
  ) u_arb (
    .req_i       (src_valid_i),
    .rr_i        (r_rr),
    .en_i        (enable_i & ~w_full),
    .grant_o     (src_ack_o),
    .gnt_idx_o   (w_gidx),
    .gnt_valid_o (w_gnt)
  );

  // Priority moves to the source after the winner; with one source this is always 0.
  assign w_rr_nxt = (w_gidx == IDX_W'(N_SRC - 1)) ? '0 : (w_gidx + IDX_W'(1));

  // Slot data and token change on the same edge; the reader's token
  // synchroniser delays visibility until the data has settled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr <= '0;
      r_wt   <= '0;
      r_slot <= '0;
      r_rr   <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_oob) begin
        r_err <= 1'b1;
      end
      if (w_gnt) begin
        r_slot[r_wptr[PTR_W-2:0]] <= src_id_i[w_gidx];
        r_wptr                    <= w_wptr_nxt;
        r_wt                      <= PTR_W'(bin2gray(32'(w_wptr_nxt)));
        r_rr                      <= w_rr_nxt;
      end
    end
  end

  assign evt_wt_o = r_wt;
  assign evt_da_o = r_slot;
  assign fill_o   = w_oob ? PTR_W'(BUFFER_DEPTH) : w_diff;
  assign full_o   = w_full;
  assign err_o    = r_err;

endmodule

// File: tb/tb_soc_evt_dc_tx.sv
`timescale 1ns/1ps
module tb_soc_evt_dc_tx;
  import soc_evt_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 en;
  logic [3:0]           src_valid;
  logic [3:0][7:0]      src_id;
  logic [3:0]           src_ack;
  logic [3:0]           evt_wt;
  logic [3:0]           evt_rp;
  logic [7:0][7:0]      evt_da;
  logic [3:0]           fill;
  logic                 full;
  logic                 err;

  soc_evt_dc_tx #(
    .N_SRC        (4),
    .EVNT_WIDTH   (8),
    .BUFFER_DEPTH (8)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .enable_i    (en),
    .src_valid_i (src_valid),
    .src_id_i    (src_id),
    .src_ack_o   (src_ack),
    .evt_wt_o    (evt_wt),
    .evt_rp_i    (evt_rp),
    .evt_da_o    (evt_da),
    .fill_o      (fill),
    .full_o      (full),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  // Hand-written 4-bit Gray code table, index = binary value.
  logic [3:0] gray_tab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  typedef struct {
    int         src;
    evt_id_t    id;
    int         slot;
    logic [3:0] wt;
  } exp_t;

  exp_t exp_q[$];
  exp_t pend_e;
  bit   pend = 0;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int s, input evt_id_t id, input int slot, input logic [3:0] wt);
    exp_t e;
    e.src = s; e.id = id; e.slot = slot; e.wt = wt;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || pend) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drain", 64'(exp_q.size()) + 64'(pend), 64'd0);
  endtask

  // Monitor: every ack pops one expected entry; the slot contents and the
  // write token are checked on the following cycle, after the write edge.
  always @(negedge clk) begin
    if (pend) begin
      chk("slot_data", 64'(evt_da[pend_e.slot]), 64'(pend_e.id));
      chk("wr_token", 64'(evt_wt), 64'(pend_e.wt));
      pend = 0;
    end
    if (rst_n && src_ack != 4'b0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_ack", 64'(src_ack), 64'd0);
      end else begin
        pend_e = exp_q.pop_front();
        chk("ack_vec", 64'(src_ack), 64'(4'b0001 << pend_e.src));
        pend = 1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_chk=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    en        = 1'b1;
    src_valid = '0;
    src_id    = '0;
    evt_rp    = '0;
    #3;
    chk("rst_wt", 64'(evt_wt), 64'd0);
    chk("rst_slots", 64'(evt_da), 64'd0);
    chk("rst_ack", 64'(src_ack), 64'd0);
    chk("rst_fill", 64'(fill), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    step();
    rst_n = 1'b1;
    step();

    // Single event from source 2.
    src_id[2]    = 8'h5A;
    src_valid[2] = 1'b1;
    push(2, 8'h5A, 0, 4'b0001);
    step();
    src_valid[2] = 1'b0;
    @(negedge clk);
    chk("single_fill", 64'(fill), 64'd1);
    wait_drain();

    // Fill to full with source 0; the reader sits at 1, so the buffer starts empty.
    step();
    evt_rp       = gray_tab[1];
    src_valid[0] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      src_id[0] = 8'h10 + 8'(k);
      push(0, src_id[0], (1 + k) % 8, gray_tab[2 + k]);
      step();
    end
    src_id[0] = 8'h18;
    @(negedge clk);
    chk("full_flag", 64'(full), 64'd1);
    chk("full_fill", 64'(fill), 64'd8);
    chk("full_noack", 64'(src_ack), 64'd0);
    step();
    step();
    // Reader frees one slot; the held request goes through into slot 1.
    push(0, 8'h18, 1, gray_tab[10]);
    evt_rp = gray_tab[2];
    step();
    src_valid[0] = 1'b0;
    @(negedge clk);
    chk("refull_flag", 64'(full), 64'd1);
    wait_drain();

    // Round-robin: all sources valid, buffer emptied first; priority starts at 1.
    step();
    evt_rp    = gray_tab[10];
    src_id    = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    src_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      push((1 + k) % 4, 8'hA0 + 8'((1 + k) % 4), (10 + k) % 8, gray_tab[(11 + k) % 16]);
    end
    repeat (8) step();
    src_valid = 4'h0;
    @(negedge clk);
    chk("rr_full", 64'(full), 64'd1);
    wait_drain();

    // Wrap-around: 20 events from source 3 with the reader keeping pace.
    step();
    evt_rp       = gray_tab[2];
    src_valid[3] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      src_id[3] = 8'h40 + 8'(k);
      push(3, src_id[3], (18 + k) % 8, gray_tab[(19 + k) % 16]);
      step();
      evt_rp = gray_tab[(19 + k) % 16];
    end
    src_valid[3] = 1'b0;
    @(negedge clk);
    chk("wrap_fill", 64'(fill), 64'd0);
    chk("wrap_token", 64'(evt_wt), 64'(gray_tab[6]));
    wait_drain();

    // Illegal pointer: write pointer 6, read pointer 10 -> difference 12.
    step();
    evt_rp       = gray_tab[10];
    src_id[1]    = 8'h77;
    src_valid[1] = 1'b1;
    @(negedge clk);
    chk("oob_full", 64'(full), 64'd1);
    chk("oob_fill", 64'(fill), 64'd8);
    chk("oob_noack", 64'(src_ack), 64'd0);
    step();
    @(negedge clk);
    chk("oob_err", 64'(err), 64'd1);
    step();
    src_valid[1] = 1'b0;
    evt_rp       = gray_tab[6];
    step();
    @(negedge clk);
    chk("err_sticky", 64'(err), 64'd1);
    chk("legal_full", 64'(full), 64'd0);
    chk("legal_fill", 64'(fill), 64'd0);

    // Asynchronous reset clears the sticky error and buffer state.
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst2_err", 64'(err), 64'd0);
    chk("rst2_wt", 64'(evt_wt), 64'd0);
    chk("rst2_slots", 64'(evt_da), 64'd0);
    evt_rp = '0;
    #1;
    chk("rst2_fill", 64'(fill), 64'd0);
    chk("final_queue", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
